// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// Package: lsu_pkg
// Shared definitions for the load/store unit: access size codes, FSM state
// encoding and small helpers for byte-mask and alignment calculation.
//
// Optional feature macro used by the LSU: LSU_MISALIGN_TRAP_EN
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam int LSU_XLEN = 64;
    localparam int LSU_RD_W = 5;

    // Access size codes as presented by the ALU stage
    typedef enum logic [1:0] {
        LSU_SZ_B = 2'd0,
        LSU_SZ_H = 2'd1,
        LSU_SZ_W = 2'd2,
        LSU_SZ_D = 2'd3
    } lsu_size_e;

    // One access in flight: accept -> request -> wait for response -> hand off
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Byte-enable pattern of an access before it is moved to its lane
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            LSU_SZ_B: mask = 8'h01;
            LSU_SZ_H: mask = 8'h03;
            LSU_SZ_W: mask = 8'h0F;
            default:  mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // True when the low address bits are not a multiple of the access size
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic mis;
        case (size)
            LSU_SZ_B: mis = 1'b0;
            LSU_SZ_H: mis = addr_lo[0];
            LSU_SZ_W: mis = |addr_lo[1:0];
            default:  mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// Module: lsu_align
// Purely combinational lane steering for the LSU.
//   Stores: shift right-aligned data up to its byte lane and build the byte
//           mask; anything past the dword boundary falls off the top.
//   Loads:  shift the aligned dword down to bit 0, truncate to the access
//           size and sign- or zero-extend.
//
// Ports:
//   addr_lo      in  3   byte offset within the dword
//   size         in  2   access size code
//   is_unsigned  in  1   zero-extend loads (ignored for dword)
//   store_data   in  64  right-aligned store data
//   load_rdata   in  64  aligned dword returned by memory
//   req_wdata    out 64  store data in its byte lane
//   req_wmask    out 8   byte enables for the store
//   load_data    out 64  extracted, extended load result
// ----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [63:0] store_data,
    input  logic [63:0] load_rdata,
    output logic [63:0] req_wdata,
    output logic [7:0]  req_wmask,
    output logic [63:0] load_data
);

    logic [5:0]  shamt;
    logic [63:0] lane;

    assign shamt     = {addr_lo, 3'b000};
    assign req_wdata = store_data << shamt;
    assign req_wmask = size_byte_mask(size) << addr_lo;
    assign lane      = load_rdata >> shamt;

    // Truncate the shifted dword to the access size, then extend
    always_comb begin
        load_data = lane;
        case (size)
            LSU_SZ_B: load_data = is_unsigned ? {56'd0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
            LSU_SZ_H: load_data = is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            LSU_SZ_W: load_data = is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            default:  load_data = lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// ----------------------------------------------------------------------------
// Module: lsu
// Load/store unit downstream of the ALU. Accepts one access, issues a single
// 64-bit memory transaction over a valid/ready request channel, waits for the
// one-cycle response pulse, then holds the (extended) load result for
// writeback until it is taken. Only one access is ever in flight.
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// (no memory request, out_misalign=1, out_data=faulting address). Without it
// no check is made and out_misalign is tied low.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             access handshake from the ALU stage
//   in_addr, in_wdata, in_store,
//   in_size, in_unsigned, in_rd   access description
//   mem_req_valid/mem_req_ready   memory request handshake
//   mem_req_addr/wen/wdata/wmask  dword address, write flag, lane data, byte enables
//   mem_resp_valid/mem_resp_rdata memory response pulse and read data
//   out_valid/out_ready           writeback handshake
//   out_rd, out_wen, out_data     writeback destination, enable and data
//   out_misalign                  misaligned-access fault flag
// ----------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = LSU_XLEN,
    parameter int RD_W = LSU_RD_W
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            in_store,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [RD_W-1:0] in_rd,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [7:0]      mem_req_wmask,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_rdata,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_data,
    output logic            out_misalign
);

    lsu_state_e state, next_state;

    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            store_q;
    logic [1:0]      size_q;
    logic            unsigned_q;
    logic [RD_W-1:0] rd_q;

    logic [XLEN-1:0] lane_wdata;
    logic [7:0]      lane_wmask;
    logic [XLEN-1:0] load_data;

    logic            accept;
    logic            trap_in;
    logic            resp_take;

    lsu_align u_align (
        .addr_lo     (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .store_data  (wdata_q),
        .load_rdata  (mem_resp_rdata),
        .req_wdata   (lane_wdata),
        .req_wmask   (lane_wmask),
        .load_data   (load_data)
    );

    assign accept    = (state == ST_IDLE) && in_valid;
    assign resp_take = (state == ST_WAIT) && mem_resp_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_in = is_misaligned(in_addr[2:0], in_size);
`else
    assign trap_in = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/request outputs; request fields come from the
    // latched access so they stay stable while the request is stalled
    always_comb begin
        next_state    = state;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        out_valid     = 1'b0;
        mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
        mem_req_wen   = store_q;
        mem_req_wdata = store_q ? lane_wdata : '0;
        mem_req_wmask = store_q ? lane_wmask : 8'h00;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = trap_in ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    next_state = ST_DONE;
                end
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
        endcase
    end

    // Access latch and writeback result registers. A trapped access loads the
    // result registers directly at accept time since it never reaches memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            store_q    <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            rd_q       <= '0;
            out_rd     <= '0;
            out_wen    <= 1'b0;
            out_data   <= '0;
        end else begin
            if (accept) begin
                addr_q     <= in_addr;
                wdata_q    <= in_wdata;
                store_q    <= in_store;
                size_q     <= in_size;
                unsigned_q <= in_unsigned;
                rd_q       <= in_rd;
            end
            if (accept && trap_in) begin
                out_rd   <= in_rd;
                out_wen  <= 1'b0;
                out_data <= in_addr;
            end
            if (resp_take) begin
                out_rd   <= rd_q;
                out_wen  <= !store_q;
                out_data <= store_q ? '0 : load_data;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Fault flag follows whichever path last filled the result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_misalign <= 1'b0;
        end else if (accept && trap_in) begin
            out_misalign <= 1'b1;
        end else if (resp_take) begin
            out_misalign <= 1'b0;
        end
    end
`else
    assign out_misalign = 1'b0;
`endif

endmodule
